// File: rtl/predictor_update_ctrl.sv
// -----------------------------------------------------------------------------
// predictor_update_ctrl
//
// Write-side companion of the branch predictor. Each fetch-stage prediction
// (table index, predicted direction, entry-valid flag) is queued in program
// order. On every EX-stage branch resolution the oldest entry is popped. One
// cycle later the predictor write port is driven with that index and the
// actual direction. A mispredict pulse is raised when a trained entry
// predicted the wrong direction.
//
// Ports
//   cpu_clk, cpu_rst          core clock; synchronous active-high reset
//   pred_push/idx/taken/
//     entry_valid             prediction issued by IF this cycle
//   q_full, q_empty           queue occupancy status
//   resolve_valid/taken       EX resolved the oldest in-flight branch
//   flush                     squash every unresolved in-flight prediction
//   predictor_wen/waddr,
//     branch_taken_ex         registered predictor write port
//   mispredict                one-cycle pulse for a wrong trained prediction
//   resolve_cnt               saturating count of matched resolutions
//   mispredict_cnt            saturating count of mispredictions
//   err_sticky                [0] push while full, [1] resolve while empty
// -----------------------------------------------------------------------------
module predictor_update_ctrl #(
  parameter int entry_num  = 256,
  parameter int addr_width = $clog2(entry_num),
  parameter int q_depth    = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  pred_push,
  input  logic [addr_width-1:0] pred_idx,
  input  logic                  pred_taken,
  input  logic                  pred_entry_valid,
  output logic                  q_full,
  output logic                  q_empty,
  input  logic                  resolve_valid,
  input  logic                  resolve_taken,
  input  logic                  flush,
  output logic                  predictor_wen,
  output logic [addr_width-1:0] predictor_waddr,
  output logic                  branch_taken_ex,
  output logic                  mispredict,
  output logic [15:0]           resolve_cnt,
  output logic [15:0]           mispredict_cnt,
  output logic [1:0]            err_sticky
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PtrW = $clog2(q_depth) + 1;
  localparam int IdxW = PtrW - 1;

  typedef struct packed {
    logic [addr_width-1:0] idx;
    logic                  taken;
    logic                  entry_valid;
  } pred_entry_t;

  pred_entry_t           mem_q [q_depth];
  pred_entry_t           head;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  wen_q, wen_d;
  logic [addr_width-1:0] waddr_q, waddr_d;
  logic                  taken_ex_q, taken_ex_d;
  logic                  mispredict_q, mispredict_d;
  logic [15:0]           resolve_cnt_q, resolve_cnt_d;
  logic [15:0]           mispredict_cnt_q, mispredict_cnt_d;
  logic [1:0]            err_q, err_d;

  logic                  full, empty;
  logic                  do_pop, do_push;

  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign head  = mem_q[rd_ptr_q[IdxW-1:0]];

  // A pop never sees a same-cycle push (no bypass). When full, a
  // simultaneous pop frees the slot the push needs. Pushes during a flush are
  // squashed along with everything else in flight.
  assign do_pop  = resolve_valid && !empty;
  assign do_push = pred_push && !flush && (!full || resolve_valid);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    wen_d            = 1'b0;
    waddr_d          = waddr_q;
    taken_ex_d       = taken_ex_q;
    mispredict_d     = 1'b0;
    resolve_cnt_d    = resolve_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    err_d            = err_q;

    if (do_pop) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      wen_d         = 1'b1;
      waddr_d       = head.idx;
      taken_ex_d    = resolve_taken;
      mispredict_d  = head.entry_valid && (head.taken != resolve_taken);
      resolve_cnt_d = (resolve_cnt_q == 16'hFFFF) ? resolve_cnt_q
                                                  : resolve_cnt_q + 16'd1;
      if (mispredict_d) begin
        mispredict_cnt_d = (mispredict_cnt_q == 16'hFFFF) ? mispredict_cnt_q
                                                          : mispredict_cnt_q + 16'd1;
      end
    end else if (resolve_valid) begin
      err_d[1] = 1'b1;
    end

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (pred_push && full && !resolve_valid && !flush) begin
      err_d[0] = 1'b1;
    end

    // The head pop above has already been taken into account. Everything
    // still queued behind it is discarded.
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      wen_q            <= 1'b0;
      waddr_q          <= '0;
      taken_ex_q       <= 1'b0;
      mispredict_q     <= 1'b0;
      resolve_cnt_q    <= '0;
      mispredict_cnt_q <= '0;
      err_q            <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      wen_q            <= wen_d;
      waddr_q          <= waddr_d;
      taken_ex_q       <= taken_ex_d;
      mispredict_q     <= mispredict_d;
      resolve_cnt_q    <= resolve_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      err_q            <= err_d;
    end
  end

  // NOTE: queue storage is deliberately not reset. The pointers alone decide
  // which slots are live, so stale contents are never observed.
  always_ff @(posedge cpu_clk) begin
    if (do_push && !cpu_rst) begin
      mem_q[wr_ptr_q[IdxW-1:0]] <= '{idx: pred_idx, taken: pred_taken,
                                     entry_valid: pred_entry_valid};
    end
  end

  assign q_full          = full;
  assign q_empty         = empty;
  assign predictor_wen   = wen_q;
  assign predictor_waddr = waddr_q;
  assign branch_taken_ex = taken_ex_q;
  assign mispredict      = mispredict_q;
  assign resolve_cnt     = resolve_cnt_q;
  assign mispredict_cnt  = mispredict_cnt_q;
  assign err_sticky      = err_q;

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for predictor_update_ctrl. A queue-based reference model
// tracks in-flight predictions, the expected write port and the counters. It
// is compared against the DUT after every clock. Directed scenarios come first,
// then randomized traffic, then a long saturation run.
// -----------------------------------------------------------------------------
module tb_predictor_update_ctrl;

  localparam int QDepth = 4;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst;
  logic       pred_push, pred_taken, pred_entry_valid;
  logic [7:0] pred_idx;
  logic       q_full, q_empty;
  logic       resolve_valid, resolve_taken, flush;
  logic       predictor_wen, branch_taken_ex, mispredict;
  logic [7:0] predictor_waddr;
  logic [15:0] resolve_cnt, mispredict_cnt;
  logic [1:0] err_sticky;

  predictor_update_ctrl #(.entry_num(256), .q_depth(QDepth)) dut (
    .cpu_clk          (cpu_clk),
    .cpu_rst          (cpu_rst),
    .pred_push        (pred_push),
    .pred_idx         (pred_idx),
    .pred_taken       (pred_taken),
    .pred_entry_valid (pred_entry_valid),
    .q_full           (q_full),
    .q_empty          (q_empty),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .predictor_wen    (predictor_wen),
    .predictor_waddr  (predictor_waddr),
    .branch_taken_ex  (branch_taken_ex),
    .mispredict       (mispredict),
    .resolve_cnt      (resolve_cnt),
    .mispredict_cnt   (mispredict_cnt),
    .err_sticky       (err_sticky)
  );

  always #5 cpu_clk = ~cpu_clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] idx;
    logic       taken;
    logic       valid;
  } ent_t;

  ent_t       mq[$];
  logic       m_wen, m_taken_ex, m_mis;
  logic [7:0] m_waddr;
  int         m_rc, m_mc;
  logic [1:0] m_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle's inputs, advance the model across the edge and compare.
  task automatic step(input logic r, input logic p, input logic [7:0] ix,
                      input logic pt, input logic pv, input logic rv,
                      input logic rt, input logic fl);
    ent_t h;
    bit   was_full;
    cpu_rst = r; pred_push = p; pred_idx = ix; pred_taken = pt;
    pred_entry_valid = pv; resolve_valid = rv; resolve_taken = rt; flush = fl;
    @(posedge cpu_clk);
    if (r) begin
      mq.delete();
      m_wen = 0; m_waddr = 0; m_taken_ex = 0; m_mis = 0;
      m_rc = 0; m_mc = 0; m_err = 0;
    end else begin
      was_full = (mq.size() == QDepth);
      m_wen = 0; m_mis = 0;
      if (rv && mq.size() > 0) begin
        h = mq.pop_front();
        m_wen = 1; m_waddr = h.idx; m_taken_ex = rt;
        m_mis = h.valid && (h.taken != rt);
        if (m_rc < 65535) m_rc++;
        if (m_mis && m_mc < 65535) m_mc++;
      end else if (rv) begin
        m_err[1] = 1'b1;
      end
      if (fl) mq.delete();
      else if (p) begin
        if (!was_full || rv) mq.push_back('{idx: ix, taken: pt, valid: pv});
        else m_err[0] = 1'b1;
      end
    end
    #1;
    check("wen",      32'(predictor_wen),   32'(m_wen));
    check("waddr",    32'(predictor_waddr), 32'(m_waddr));
    check("taken_ex", 32'(branch_taken_ex), 32'(m_taken_ex));
    check("mispred",  32'(mispredict),      32'(m_mis));
    check("q_full",   32'(q_full),          32'(mq.size() == QDepth));
    check("q_empty",  32'(q_empty),         32'(mq.size() == 0));
    check("rcnt",     32'(resolve_cnt),     32'(m_rc));
    check("mcnt",     32'(mispredict_cnt),  32'(m_mc));
    check("err",      32'(err_sticky),      32'(m_err));
  endtask

  task automatic idle();
    step(0, 0, 8'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [7:0] ix, input logic pt, input logic pv);
    step(0, 1, ix, pt, pv, 0, 0, 0);
  endtask

  task automatic resolve(input logic rt);
    step(0, 0, 8'd0, 0, 0, 1, rt, 0);
  endtask

  initial begin
    cpu_rst = 1; pred_push = 0; pred_idx = 0; pred_taken = 0;
    pred_entry_valid = 0; resolve_valid = 0; resolve_taken = 0; flush = 0;

    // Reset state, checked against literal constants as well.
    step(1, 1, 8'hAA, 1, 1, 1, 1, 0);
    check("rst_empty", 32'(q_empty), 32'd1);
    check("rst_full",  32'(q_full),  32'd0);
    check("rst_wen",   32'(predictor_wen), 32'd0);

    // 1: trained mispredict
    push(8'd5, 1, 1);
    resolve(0);
    check("t1_waddr", 32'(predictor_waddr), 32'd5);
    check("t1_mis",   32'(mispredict), 32'd1);
    check("t1_cnt",   32'({resolve_cnt, mispredict_cnt}), 32'h0001_0001);
    check("t1_empty", 32'(q_empty), 32'd1);
    idle();
    check("t1_pulse", 32'(predictor_wen), 32'd0);

    // 2: fill, overflow, drain in order
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) push(8'(i), 0, 1);
    check("t2_full", 32'(q_full), 32'd1);
    push(8'd99, 1, 1);
    check("t2_err", 32'(err_sticky), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      resolve(0);
      check("t2_order", 32'(predictor_waddr), 32'(i));
    end
    check("t2_empty", 32'(q_empty), 32'd1);

    // 3: push and resolve together while full
    for (int i = 1; i <= 4; i++) push(8'(i + 10), 1, 1);
    step(0, 1, 8'd9, 1, 1, 1, 1, 0);
    check("t3_head", 32'(predictor_waddr), 32'd11);
    check("t3_full", 32'(q_full), 32'd1);
    for (int i = 0; i < 4; i++) resolve(1);
    check("t3_tail", 32'(predictor_waddr), 32'd9);

    // 4: untrained entry
    step(1, 0, 0, 0, 0, 0, 0, 0);
    push(8'd7, 1, 0);
    resolve(0);
    check("t4_wen", 32'(predictor_wen), 32'd1);
    check("t4_mis", 32'({mispredict, mispredict_cnt}), 32'd0);

    // 5: resolve + flush
    for (int i = 0; i < 3; i++) push(8'(20 + i), 0, 1);
    step(0, 1, 8'd30, 0, 1, 1, 0, 1);
    check("t5_waddr", 32'(predictor_waddr), 32'd20);
    check("t5_empty", 32'(q_empty), 32'd1);
    resolve(0);
    check("t5_nowen", 32'(predictor_wen), 32'd0);

    // Randomized traffic
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 60),
           8'($urandom),
           1'($urandom), 1'($urandom),
           ($urandom_range(0, 99) < 50),
           1'($urandom),
           ($urandom_range(0, 99) < 5));
    end

    // 6: counter saturation, then resolve on empty
    step(1, 0, 0, 0, 0, 0, 0, 0);
    push(8'd1, 1, 1);
    for (int n = 0; n < 65540; n++) step(0, 1, 8'(n), 1, 1, 1, 0, 0);
    resolve(0);
    check("t6_rsat", 32'(resolve_cnt), 32'hFFFF);
    check("t6_msat", 32'(mispredict_cnt), 32'hFFFF);
    resolve(0);
    check("t6_wen",  32'(predictor_wen), 32'd0);
    check("t6_err",  32'(err_sticky[1]), 32'd1);
    check("t6_hold", 32'(resolve_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
